// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode encoding,
// controller state encoding, flag bundle and default widths.
package alu_pkg;

  localparam int W_DEF = 64;
  localparam int N_DEF = 4;

  // Opcode values occupy the low four bits of ALUControl; any set bit
  // above bit 3 makes the code unknown, which passes a through.
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_LSL  = 4'b1000,
    OP_LSR  = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between a requester and alu_mc.
interface alu_mc_if import alu_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [N-1:0] ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         neg;
  logic         carry;
  logic         ovf;

  modport master (
    output in_valid, a, b, ALUControl, out_ready,
    input  in_ready, out_valid, result, zero, neg, carry, ovf
  );

  modport slave (
    input  in_valid, a, b, ALUControl, out_ready,
    output in_ready, out_valid, result, zero, neg, carry, ovf
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, always W
// steps (no early exit) so the caller sees a fixed latency. Only the low W
// product bits are kept.
module mul_iter import alu_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  // Wide enough to hold W itself so the step count never wraps.
  localparam int CW = $clog2(W + 1);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  acc_d;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  mplier_q;

  // Accumulator after the current step; on the last step this is the
  // finished product, handed out combinationally so the caller can register
  // it on the same edge that completes the multiply.
  always_comb begin
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    product = acc_d;
    done    = run_q && (cnt_q == CW'(W - 1));
  end

  // Step state: load on start, then shift multiplicand left and multiplier
  // right once per cycle until W steps have been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake. Single-cycle ops complete one
// cycle after accept; MUL runs through mul_iter for exactly W+1 cycles.
// The result and flags are held in DONE until the consumer retires them.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | ready for a new operation (only state with in_ready = 1)
//  BUSY    | MUL in progress, one shift-add step per cycle
//  DONE    | result/flags valid and held until out_ready
module alu_mc import alu_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);

  localparam int SW = $clog2(W);

  alu_state_e   state_q;
  alu_state_e   state_d;
  logic [W-1:0] result_q;
  logic [W-1:0] result_d;
  alu_flags_t   flags_q;
  alu_flags_t   flags_d;

  logic          accept;
  logic          op_known;
  logic [3:0]    op4;
  logic          is_mul;
  logic [SW-1:0] shamt;
  logic [W:0]    sum_w;
  logic [W-1:0]  diff;
  logic [W-1:0]  alu_res;
  logic          alu_carry;
  logic          alu_ovf;

  logic          mul_start;
  logic          mul_done;
  logic [W-1:0]  mul_product;

  // Single-cycle datapath: result and carry/overflow for the presented op.
  always_comb begin
    op4       = bus.ALUControl[3:0];
    op_known  = ((bus.ALUControl >> 4) == '0);
    shamt     = bus.b[SW-1:0];
    sum_w     = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = bus.a - bus.b;
    alu_res   = bus.a;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    is_mul    = 1'b0;
    if (op_known) begin
      case (op4)
        OP_AND:   alu_res = bus.a & bus.b;
        OP_OR:    alu_res = bus.a | bus.b;
        OP_XOR:   alu_res = bus.a ^ bus.b;
        OP_PASSB: alu_res = bus.b;
        OP_ADD: begin
          alu_res   = sum_w[W-1:0];
          alu_carry = sum_w[W];
          // Same-sign operands producing an opposite-sign sum.
          alu_ovf   = (bus.a[W-1] == bus.b[W-1]) && (sum_w[W-1] != bus.a[W-1]);
        end
        OP_SUB: begin
          alu_res   = diff;
          // Carry means "no borrow", ARM-style.
          alu_carry = (bus.a >= bus.b);
          alu_ovf   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
        end
        OP_LSL:   alu_res = bus.a << shamt;
        OP_LSR:   alu_res = bus.a >> shamt;
        OP_MUL:   is_mul  = 1'b1;
        default:  alu_res = bus.a;
      endcase
    end
  end

  // Controller next state: accept in IDLE, wait for the multiplier in BUSY,
  // hold until retire in DONE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    accept    = bus.in_valid && bus.in_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            result_d = alu_res;
            flags_d  = {(alu_res == '0), alu_res[W-1], alu_carry, alu_ovf};
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          result_d = mul_product;
          flags_d  = {(mul_product == '0), mul_product[W-1], 1'b0, 1'b0};
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and flag registers; reset overrides accept and retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  mul_iter #(.W(W)) u_mul_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // in_ready is masked by reset so nothing can be accepted while it is high.
  assign bus.in_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.neg       = flags_q.neg;
  assign bus.carry     = flags_q.carry;
  assign bus.ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at W=64: directed corner cases plus a
// random operation mix checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 64;
  localparam int N = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_mc_if #(.W(W), .N(N)) bus ();

  alu_mc #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: results and {zero,neg,carry,ovf} straight from the op rules.
  function automatic void ref_model(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] r,
                                    output logic [3:0] f);
    logic [64:0]        wide;
    logic signed [64:0] sx;
    logic               c;
    logic               o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0111: r = b;
      4'b0010: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[63:0];
        c    = wide[64];
        sx   = $signed({a[63], a}) + $signed({b[63], b});
        o    = (sx[64] != sx[63]);
      end
      4'b0110: begin
        r  = a - b;
        c  = (a >= b);
        sx = $signed({a[63], a}) - $signed({b[63], b});
        o  = (sx[64] != sx[63]);
      end
      4'b1000: r = a << b[5:0];
      4'b1001: r = a >> b[5:0];
      4'b1010: r = a * b;
      default: r = a;
    endcase
    f = {(r == 64'd0), r[63], c, o};
  endfunction

  // Present one op, wait for out_valid (bounded), check latency and outputs.
  // Leaves the DUT in DONE; caller retires.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] er, output logic [3:0] ef);
    int lat;
    int exp_lat;
    int ready_ok;
    ref_model(op, a, b, er, ef);
    exp_lat = (op == 4'b1010) ? W + 1 : 1;
    check($sformatf("ready_before_op%0h", op), {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.a          = a;
    bus.b          = b;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    lat      = 1;
    ready_ok = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) ready_ok = 0;
      bus.a          = {$urandom, $urandom};
      bus.b          = {$urandom, $urandom};
      bus.ALUControl = 4'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency_op%0h", op), 64'(lat), 64'(exp_lat));
    check($sformatf("busy_not_ready_op%0h", op), 64'(ready_ok), 64'd1);
    check($sformatf("result_op%0h a=%h b=%h", op, a, b), bus.result, er);
    check($sformatf("flags_op%0h a=%h b=%h", op, a, b),
          {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, {60'd0, ef});
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("retire_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("retire_in_ready", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] er;
    logic [3:0]  ef;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [3:0]  op_pool [13];
    int          seen;

    op_pool = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                4'h4, 4'h5, 4'hB, 4'hF};
    tests = 0;
    fails = 0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.ALUControl = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_flags", {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 64'd0);
    check("rst_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready_after", {63'd0, bus.in_ready}, 64'd1);

    // Directed corner cases
    issue(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, er, ef);
    check("add_ovf_result", bus.result, 64'h8000_0000_0000_0000);
    check("add_ovf_flags", {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 64'b0101);
    retire();
    issue(4'b0110, 64'd5, 64'd5, er, ef);
    check("sub_eq_flags", {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 64'b1010);
    retire();
    issue(4'b0110, 64'd3, 64'd5, er, ef);
    check("sub_neg_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_neg_flags", {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, 64'b0100);
    retire();
    issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, er, ef);
    retire();
    issue(4'b1010, 64'd12345, 64'd678, er, ef);
    check("mul_directed", bus.result, 64'd8369910);
    retire();
    issue(4'b1000, 64'd1, 64'h43, er, ef);
    check("lsl_masked", bus.result, 64'h8);
    retire();
    issue(4'b1001, 64'h80, 64'd7, er, ef);
    check("lsr_7", bus.result, 64'h1);
    retire();
    issue(4'b1000, 64'hDEAD_BEEF_0000_1234, 64'h40, er, ef);
    check("lsl_zero_amount", bus.result, 64'hDEAD_BEEF_0000_1234);
    retire();

    // Hold in DONE while inputs churn
    issue(4'b0011, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, er, ef);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid   = 1'($urandom);
      bus.a          = {$urandom, $urandom};
      bus.b          = {$urandom, $urandom};
      bus.ALUControl = 4'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("hold_result_%0d", i), bus.result, er);
      check($sformatf("hold_flags_%0d", i),
            {60'd0, bus.zero, bus.neg, bus.carry, bus.ovf}, {60'd0, ef});
      check($sformatf("hold_valid_%0d", i), {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
    end
    bus.in_valid = 1'b0;
    retire();

    // Reset beats retire and accept in the same cycle
    issue(4'b0001, 64'hF0, 64'h0F, er, ef);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("rst_prio_result", bus.result, 64'd0);
    check("rst_prio_valid", {63'd0, bus.out_valid}, 64'd0);
    reset = 1'b0;
    #1;
    check("rst_prio_ready", {63'd0, bus.in_ready}, 64'd1);

    // Reset 20 cycles into a MUL abandons it
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'b1010;
    bus.a          = 64'd12345;
    bus.b          = 64'd678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mulrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mulrst_result", bus.result, 64'd0);
    reset = 1'b0;
    #1;
    check("mulrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    seen = 0;
    repeat (W + 10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("mulrst_no_stale_valid", 64'(seen), 64'd0);
    issue(4'b0000, 64'hF0, 64'h3C, er, ef);
    check("and_after_reset", bus.result, 64'h30);
    retire();

    // Random operation mix
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 64'($urandom_range(0, 70));
        default: rb = {$urandom, $urandom};
      endcase
      issue(op_pool[$urandom_range(0, 12)], ra, rb, er, ef);
      retire();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
